wb_bus_master: RTL and testbench
================================

Name: wb_bus_master

Overview:
- Wishbone classic-cycle initiator that bridges one CPU pipeline port (instruction fetch or load/store) onto the shared Wishbone bus.
- Targets include the instruction ROM, UART and GPIO slaves.
- Converts a single-cycle CPU request into a full CYC/STB/ACK transaction and asserts a pipeline stall request until the transaction completes.
- Supports flush abort, a bus-error/timeout watchdog, and pipeline-stall holding of returned read data.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 16: maximum cycles to wait for wb_ack_i/wb_err_i before aborting; must be ≥ 2.
- TW, 5: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- wb_clk_i  in  1  system clock; all state changes on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- cpu_ce_i  in  1  CPU request valid.
- cpu_addr_i  in  AW  request byte address.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_sel_i  in  4  byte lane enables.
- cpu_data_i  in  DW  write data.
- cpu_data_o  out  DW  read data returned to the pipeline.
- stallreq_o  out  1  stall request to the pipeline controller.
- stall_i  in  1  this pipeline stage is stalled by another source.
- flush_i  in  1  pipeline flush; abort any transaction.
- bus_err_o  out  1  one-cycle pulse on wb_err_i or timeout.
- wb_adr_o  out  AW  Wishbone address.
- wb_dat_o  out  DW  Wishbone write data.
- wb_dat_i  in  DW  Wishbone read data.
- wb_sel_o  out  4  Wishbone byte select.
- wb_we_o  out  1  Wishbone write enable.
- wb_stb_o  out  1  Wishbone strobe.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.

Behaviour:
- Reset (wb_rst_i = 0, asynchronous):
  - state = IDLE.
  - wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o = 0.
  - bus_err_o = 0; rd_buf = 0; timeout counter = 0.
  - cpu_data_o = 0 and stallreq_o = 0, because both follow state.
- All Wishbone outputs are registered. stallreq_o and cpu_data_o are combinational from state and the bus inputs.
- IDLE:
  - If cpu_ce_i = 1 and flush_i = 0: register adr/dat/sel/we from the cpu_* inputs, set stb = cyc = 1, clear the counter, go to BUSY.
  - stallreq_o = cpu_ce_i & !flush_i.
  - cpu_data_o = 0.
- BUSY: stb, cyc, adr, dat, sel and we are held constant. Priority order:
  1. flush_i = 1: drop stb/cyc, go to IDLE, discard any ack in the same cycle; stallreq_o = 0.
  2. wb_ack_i = 1: drop stb/cyc, clear we/sel.
     - rd_buf <= wb_dat_i if read, else 0.
     - stallreq_o = 0 this cycle.
     - cpu_data_o = wb_dat_i if read, else 0.
     - Next state is WAIT_STALL if stall_i = 1, else IDLE.
  3. wb_err_i = 1, or counter = TIMEOUT-1: treated as ack with data = 0; bus_err_o pulses 1 next cycle.
  4. Otherwise: counter++, stallreq_o = 1, cpu_data_o = 0.
- WAIT_STALL:
  - stallreq_o = 0; cpu_data_o = rd_buf; bus idle.
  - When stall_i = 0: go to IDLE.
  - flush_i: go to IDLE immediately.
- Back-to-back requests: after ack, at least one IDLE cycle with cyc = 0 precedes the next cycle. Minimum cost is 2 cycles per transfer plus slave wait states.
- Write-phase data is never reflected on cpu_data_o.
- wb_ack_i or wb_err_i arriving while cyc_o = 0 is ignored.
- Simultaneous ack and err: ack wins and bus_err_o stays 0.
- The counter saturates and does not wrap, because the abort occurs at TIMEOUT-1.
- No byte reordering. Endianness is the slave's responsibility; data passes through bit-exact.
- State encoding is one-hot or binary, implementer's choice. No other states are permitted; an illegal state recovers to IDLE.

Test Plan:
- Read, 3-wait-state slave: cpu_ce_i = 1, addr = 0x0000_0010, we = 0; slave acks in the 4th BUSY cycle with 0xDEADBEEF -> cyc/stb high for exactly 4 cycles, stallreq_o high until the ack cycle, cpu_data_o = 0xDEADBEEF in the ack cycle.
- Write: addr = 0x1000_0004, sel = 4'b0011, data = 0x0000_A55A -> wb_we_o = 1, wb_sel_o = 0011, wb_dat_o = 0x0000A55A held stable until ack; cpu_data_o = 0 throughout.
- Stall hold: read ack with 0x12345678 while stall_i = 1 for 3 cycles -> WAIT_STALL; cpu_data_o = 0x12345678 for all 3 cycles, bus idle, then IDLE.
- Flush abort: flush_i asserted in the 2nd BUSY cycle, ack asserted in the same cycle -> cyc/stb drop next edge, cpu_data_o = 0, no data captured, stallreq_o = 0.
- Timeout: no ack, TIMEOUT = 16 -> cyc drops after 16 BUSY cycles, bus_err_o one-cycle pulse, cpu_data_o = 0.
- Async reset mid-BUSY: pull wb_rst_i low between clock edges -> wb_cyc_o/wb_stb_o = 0 immediately; after release, a new request starts cleanly from IDLE.

Source files
------------

// File: rtl/wb_bus_master.sv
// wb_bus_master: Wishbone classic-cycle initiator for one CPU pipeline port.
//
// Turns a single-cycle CPU request into a CYC/STB/ACK transaction and raises
// a stall request until the transaction completes. It also handles:
//   - a pipeline flush, which aborts the transaction,
//   - a bus-error / timeout watchdog,
//   - holding returned read data while the pipeline stage is stalled.
//
// Ports:
//   wb_clk_i, wb_rst_i       clock; asynchronous active-low reset
//   cpu_ce_i/addr/we/sel/data CPU request (valid, address, write, lanes, wdata)
//   cpu_data_o, stallreq_o   read data to the pipeline; stall request
//   stall_i, flush_i         stage stalled elsewhere; pipeline flush
//   bus_err_o                one-cycle pulse on wb_err_i or timeout
//   wb_*                     Wishbone initiator interface (outputs registered)

module wb_bus_master #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cpu_ce_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic          cpu_we_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic [DW-1:0] cpu_data_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          stallreq_o,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic          bus_err_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StBusy      = 2'd1,
        StWaitStall = 2'd2
    } state_e;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_adr, w_adr_d;
    logic [DW-1:0] r_dat, w_dat_d;
    logic [3:0]    r_sel, w_sel_d;
    logic          r_we, w_we_d;
    logic          r_stb, w_stb_d;
    logic          r_cyc, w_cyc_d;
    logic          r_bus_err, w_bus_err_d;
    logic [DW-1:0] r_rd_buf, w_rd_buf_d;
    logic [TW-1:0] r_cnt, w_cnt_d;

    logic          w_timeout;
    logic [DW-1:0] w_rd_data;

    // Abort happens at TIMEOUT-1, so the counter never needs to wrap.
    assign w_timeout = (r_cnt == TW'(TIMEOUT - 1));

    // Error/timeout completions return zero; writes never return data.
    assign w_rd_data = (wb_ack_i && !r_we) ? wb_dat_i : '0;

    always_comb begin
        w_state_d   = r_state;
        w_adr_d     = r_adr;
        w_dat_d     = r_dat;
        w_sel_d     = r_sel;
        w_we_d      = r_we;
        w_stb_d     = r_stb;
        w_cyc_d     = r_cyc;
        w_bus_err_d = 1'b0;
        w_rd_buf_d  = r_rd_buf;
        w_cnt_d     = r_cnt;
        stallreq_o  = 1'b0;
        cpu_data_o  = '0;

        unique case (r_state)
            StIdle: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    w_adr_d   = cpu_addr_i;
                    w_dat_d   = cpu_data_i;
                    w_sel_d   = cpu_sel_i;
                    w_we_d    = cpu_we_i;
                    w_stb_d   = 1'b1;
                    w_cyc_d   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StBusy;
                end
            end

            StBusy: begin
                if (flush_i) begin
                    // Any same-cycle ack is discarded.
                    w_stb_d   = 1'b0;
                    w_cyc_d   = 1'b0;
                    w_state_d = StIdle;
                end else if (wb_ack_i || wb_err_i || w_timeout) begin
                    w_stb_d     = 1'b0;
                    w_cyc_d     = 1'b0;
                    w_we_d      = 1'b0;
                    w_sel_d     = 4'b0000;
                    w_rd_buf_d  = w_rd_data;
                    cpu_data_o  = w_rd_data;
                    // Ack wins over a simultaneous error.
                    w_bus_err_d = ~wb_ack_i;
                    w_state_d   = stall_i ? StWaitStall : StIdle;
                end else begin
                    w_cnt_d    = r_cnt + TW'(1);
                    stallreq_o = 1'b1;
                end
            end

            StWaitStall: begin
                cpu_data_o = r_rd_buf;
                if (flush_i || !stall_i) begin
                    w_state_d = StIdle;
                end
            end

            default: begin
                w_stb_d   = 1'b0;
                w_cyc_d   = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state   <= StIdle;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= 4'b0000;
            r_we      <= 1'b0;
            r_stb     <= 1'b0;
            r_cyc     <= 1'b0;
            r_bus_err <= 1'b0;
            r_rd_buf  <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_d;
            r_adr     <= w_adr_d;
            r_dat     <= w_dat_d;
            r_sel     <= w_sel_d;
            r_we      <= w_we_d;
            r_stb     <= w_stb_d;
            r_cyc     <= w_cyc_d;
            r_bus_err <= w_bus_err_d;
            r_rd_buf  <= w_rd_buf_d;
            r_cnt     <= w_cnt_d;
        end
    end

    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign wb_we_o   = r_we;
    assign wb_stb_o  = r_stb;
    assign wb_cyc_o  = r_cyc;
    assign bus_err_o = r_bus_err;

endmodule

// File: tb/tb_wb_bus_master.sv
// Directed testbench for wb_bus_master. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.

module tb_wb_bus_master;

    logic        clk;
    logic        rst_n;
    logic        cpu_ce;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallreq;
    logic        stall;
    logic        flush;
    logic        bus_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_bus_master #(
        .AW      (32),
        .DW      (32),
        .TIMEOUT (16),
        .TW      (5)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .cpu_ce_i   (cpu_ce),
        .cpu_addr_i (cpu_addr),
        .cpu_we_i   (cpu_we),
        .cpu_sel_i  (cpu_sel),
        .cpu_data_i (cpu_wdata),
        .cpu_data_o (cpu_rdata),
        .stallreq_o (stallreq),
        .stall_i    (stall),
        .flush_i    (flush),
        .bus_err_o  (bus_err),
        .wb_adr_o   (wb_adr),
        .wb_dat_o   (wb_dat_w),
        .wb_dat_i   (wb_dat_r),
        .wb_sel_o   (wb_sel),
        .wb_we_o    (wb_we),
        .wb_stb_o   (wb_stb),
        .wb_cyc_o   (wb_cyc),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Present a request in IDLE; the next edge moves the DUT into BUSY.
    task automatic request(input logic [31:0] a, input logic w, input logic [3:0] s,
                           input logic [31:0] d);
        tick();
        cpu_ce    = 1'b1;
        cpu_addr  = a;
        cpu_we    = w;
        cpu_sel   = s;
        cpu_wdata = d;
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_ce    = 1'b0;
        cpu_addr  = '0;
        cpu_we    = 1'b0;
        cpu_sel   = '0;
        cpu_wdata = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        wb_dat_r  = '0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;

        // Reset state
        #2;
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_dat", wb_dat_w, 32'd0);
        check("rst_sel", 32'(wb_sel), 32'd0);
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_cpu_data", cpu_rdata, 32'd0);
        #10 rst_n = 1'b1;

        // Read with 3 wait states; ack in 4th BUSY cycle
        request(32'h0000_0010, 1'b0, 4'hF, 32'h0);
        smp();
        check("rd_idle_stallreq", 32'(stallreq), 32'd1);
        check("rd_idle_cyc", 32'(wb_cyc), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            cpu_ce = 1'b0;
            if (i == 4) begin
                wb_ack   = 1'b1;
                wb_dat_r = 32'hDEAD_BEEF;
            end
            smp();
            check("rd_cyc", 32'(wb_cyc), 32'd1);
            check("rd_stb", 32'(wb_stb), 32'd1);
            check("rd_adr", wb_adr, 32'h0000_0010);
            check("rd_stallreq", 32'(stallreq), (i < 4) ? 32'd1 : 32'd0);
            check("rd_cpu_data", cpu_rdata, (i < 4) ? 32'd0 : 32'hDEAD_BEEF);
        end
        tick();
        wb_ack   = 1'b0;
        wb_dat_r = 32'h0;
        smp();
        check("rd_done_cyc", 32'(wb_cyc), 32'd0);
        check("rd_done_stb", 32'(wb_stb), 32'd0);
        check("rd_done_stallreq", 32'(stallreq), 32'd0);
        check("rd_done_err", 32'(bus_err), 32'd0);

        // Write; read data bus carries junk that must not reach the CPU
        request(32'h1000_0004, 1'b1, 4'b0011, 32'h0000_A55A);
        for (int i = 1; i <= 2; i++) begin
            tick();
            cpu_ce    = 1'b0;
            cpu_wdata = 32'hFFFF_FFFF;
            wb_dat_r  = 32'h7777_7777;
            if (i == 2) wb_ack = 1'b1;
            smp();
            check("wr_we", 32'(wb_we), 32'd1);
            check("wr_sel", 32'(wb_sel), 32'h3);
            check("wr_dat", wb_dat_w, 32'h0000_A55A);
            check("wr_adr", wb_adr, 32'h1000_0004);
            check("wr_cpu_data", cpu_rdata, 32'd0);
        end
        tick();
        wb_ack = 1'b0;
        smp();
        check("wr_done_cyc", 32'(wb_cyc), 32'd0);
        check("wr_done_we", 32'(wb_we), 32'd0);
        check("wr_done_sel", 32'(wb_sel), 32'd0);
        check("wr_done_cpu_data", cpu_rdata, 32'd0);

        // Ack while idle is ignored
        wb_ack   = 1'b1;
        wb_dat_r = 32'h1111_2222;
        smp();
        check("idle_ack_cpu_data", cpu_rdata, 32'd0);
        tick();
        wb_ack = 1'b0;
        smp();
        check("idle_ack_cyc", 32'(wb_cyc), 32'd0);
        check("idle_ack_err", 32'(bus_err), 32'd0);

        // Stall hold: ack while stalled, data held in WAIT_STALL
        request(32'h0000_0020, 1'b0, 4'hF, 32'h0);
        tick();
        cpu_ce   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_r = 32'h1234_5678;
        stall    = 1'b1;
        smp();
        check("sh_ack_cpu_data", cpu_rdata, 32'h1234_5678);
        check("sh_ack_stallreq", 32'(stallreq), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_ack   = 1'b0;
            wb_dat_r = 32'h0;
            smp();
            check("sh_hold_cpu_data", cpu_rdata, 32'h1234_5678);
            check("sh_hold_cyc", 32'(wb_cyc), 32'd0);
            check("sh_hold_stallreq", 32'(stallreq), 32'd0);
        end
        tick();
        stall = 1'b0;
        smp();
        check("sh_release_cpu_data", cpu_rdata, 32'h1234_5678);
        tick();
        smp();
        check("sh_idle_cpu_data", cpu_rdata, 32'd0);

        // Flush in 2nd BUSY cycle with a same-cycle ack
        request(32'h0000_0030, 1'b0, 4'hF, 32'h0);
        tick();
        cpu_ce = 1'b0;
        smp();
        check("fl_busy_stallreq", 32'(stallreq), 32'd1);
        tick();
        flush    = 1'b1;
        wb_ack   = 1'b1;
        wb_dat_r = 32'hCAFE_F00D;
        smp();
        check("fl_stallreq", 32'(stallreq), 32'd0);
        check("fl_cpu_data", cpu_rdata, 32'd0);
        check("fl_cyc_same", 32'(wb_cyc), 32'd1);
        tick();
        flush  = 1'b0;
        wb_ack = 1'b0;
        smp();
        check("fl_cyc", 32'(wb_cyc), 32'd0);
        check("fl_stb", 32'(wb_stb), 32'd0);
        check("fl_cpu_data_after", cpu_rdata, 32'd0);
        check("fl_err", 32'(bus_err), 32'd0);

        // Timeout: no ack for 16 BUSY cycles
        request(32'h0000_0040, 1'b0, 4'hF, 32'h0);
        wb_dat_r = 32'h55AA_55AA;
        for (int i = 1; i <= 16; i++) begin
            tick();
            cpu_ce = 1'b0;
            smp();
            check("to_cyc", 32'(wb_cyc), 32'd1);
            check("to_stallreq", 32'(stallreq), (i < 16) ? 32'd1 : 32'd0);
            check("to_cpu_data", cpu_rdata, 32'd0);
            check("to_err_early", 32'(bus_err), 32'd0);
        end
        tick();
        smp();
        check("to_cyc_drop", 32'(wb_cyc), 32'd0);
        check("to_err_pulse", 32'(bus_err), 32'd1);
        tick();
        smp();
        check("to_err_clear", 32'(bus_err), 32'd0);

        // Bus error in first BUSY cycle
        request(32'h0000_0050, 1'b0, 4'hF, 32'h0);
        tick();
        cpu_ce = 1'b0;
        wb_err = 1'b1;
        smp();
        check("be_stallreq", 32'(stallreq), 32'd0);
        check("be_cpu_data", cpu_rdata, 32'd0);
        tick();
        wb_err = 1'b0;
        smp();
        check("be_err_pulse", 32'(bus_err), 32'd1);
        check("be_cyc", 32'(wb_cyc), 32'd0);

        // Simultaneous ack and err: ack wins
        request(32'h0000_0060, 1'b0, 4'hF, 32'h0);
        tick();
        cpu_ce   = 1'b0;
        wb_ack   = 1'b1;
        wb_err   = 1'b1;
        wb_dat_r = 32'h0BAD_F00D;
        smp();
        check("ae_cpu_data", cpu_rdata, 32'h0BAD_F00D);
        tick();
        wb_ack = 1'b0;
        wb_err = 1'b0;
        smp();
        check("ae_err", 32'(bus_err), 32'd0);

        // Async reset mid-BUSY
        request(32'h0000_0070, 1'b1, 4'hF, 32'h0000_1234);
        tick();
        cpu_ce = 1'b0;
        smp();
        check("ar_cyc_before", 32'(wb_cyc), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_cyc", 32'(wb_cyc), 32'd0);
        check("ar_stb", 32'(wb_stb), 32'd0);
        check("ar_adr", wb_adr, 32'd0);
        #1 rst_n = 1'b1;
        smp();
        check("ar_idle_cyc", 32'(wb_cyc), 32'd0);
        check("ar_idle_stallreq", 32'(stallreq), 32'd0);
        request(32'h0000_0080, 1'b0, 4'hF, 32'h0);
        tick();
        cpu_ce   = 1'b0;
        wb_ack   = 1'b1;
        wb_dat_r = 32'hA5A5_0F0F;
        smp();
        check("ar_new_adr", wb_adr, 32'h0000_0080);
        check("ar_new_cyc", 32'(wb_cyc), 32'd1);
        check("ar_new_cpu_data", cpu_rdata, 32'hA5A5_0F0F);
        tick();
        wb_ack = 1'b0;
        smp();
        check("ar_new_done", 32'(wb_cyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
